// File: rtl/lcd_sync_module.sv
// Raster timing generator for a parallel RGB panel: pixel-stage addressing plus
// active-low hsync/vsync and data-enable retimed by a configurable delay line.
module lcd_sync_module #(
   parameter int unsigned H_SYNC   = 128,
   parameter int unsigned H_BP     = 88,
   parameter int unsigned H_ACTIVE = 800,
   parameter int unsigned H_FP     = 40,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned PIPE_DLY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        ready_sig,
   output logic [10:0] column_addr_sig,
   output logic [10:0] row_addr_sig,
   output logic        frame_start_sig,
   output logic        lcd_hsync,
   output logic        lcd_vsync,
   output logic        lcd_de
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int unsigned H_START = H_SYNC + H_BP;
   localparam int unsigned V_START = V_SYNC + V_BP;

   localparam logic [10:0] HLast   = 11'(H_TOTAL - 1);
   localparam logic [10:0] VLast   = 11'(V_TOTAL - 1);
   localparam logic [10:0] HStartW = 11'(H_START);
   localparam logic [10:0] VStartW = 11'(V_START);
   localparam logic [10:0] HEndW   = 11'(H_START + H_ACTIVE);
   localparam logic [10:0] VEndW   = 11'(V_START + V_ACTIVE);
   localparam logic [10:0] HSyncW  = 11'(H_SYNC);
   localparam logic [10:0] VSyncW  = 11'(V_SYNC);

   logic [10:0] h_cnt_q, h_cnt_d;
   logic [10:0] v_cnt_q, v_cnt_d;
   logic        h_wrap, v_wrap, h_vis, v_vis;

   logic        ready_q, ready_d;
   logic [10:0] col_q, col_d;
   logic [10:0] row_q, row_d;
   logic        fs_q, fs_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;

   always_comb begin
      h_wrap = (h_cnt_q == HLast);
      v_wrap = (v_cnt_q == VLast);
      h_cnt_d = '0;
      v_cnt_d = '0;
      if (en) begin
         h_cnt_d = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
         v_cnt_d = v_cnt_q;
         if (h_wrap) begin
            v_cnt_d = v_wrap ? 11'd0 : v_cnt_q + 11'd1;
         end
      end

      h_vis   = (h_cnt_q >= HStartW) && (h_cnt_q < HEndW);
      v_vis   = (v_cnt_q >= VStartW) && (v_cnt_q < VEndW);
      ready_d = en && h_vis && v_vis;
      col_d   = ready_d ? (h_cnt_q - HStartW) : 11'd0;
      row_d   = ready_d ? (v_cnt_q - VStartW) : 11'd0;
      fs_d    = en && (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
      hs_d    = !(en && (h_cnt_q < HSyncW));
      vs_d    = !(en && (v_cnt_q < VSyncW));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         ready_q <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
         fs_q    <= 1'b0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         ready_q <= ready_d;
         col_q   <= col_d;
         row_q   <= row_d;
         fs_q    <= fs_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
      end
   end

   assign ready_sig       = ready_q;
   assign column_addr_sig = col_q;
   assign row_addr_sig    = row_q;
   assign frame_start_sig = fs_q;

   // Panel-side delay line; runs every cycle so a dropped enable drains to idle.
   if (PIPE_DLY > 0) begin : g_dly
      logic [PIPE_DLY-1:0] de_dly_q, hs_dly_q, vs_dly_q;
      logic [PIPE_DLY:0]   de_line, hs_line, vs_line;

      assign de_line = {de_dly_q, ready_q};
      assign hs_line = {hs_dly_q, hs_q};
      assign vs_line = {vs_dly_q, vs_q};

      always_ff @(posedge clk) begin
         if (rst) begin
            de_dly_q <= '0;
            hs_dly_q <= '1;
            vs_dly_q <= '1;
         end else begin
            de_dly_q <= de_line[PIPE_DLY-1:0];
            hs_dly_q <= hs_line[PIPE_DLY-1:0];
            vs_dly_q <= vs_line[PIPE_DLY-1:0];
         end
      end

      assign lcd_de    = de_dly_q[PIPE_DLY-1];
      assign lcd_hsync = hs_dly_q[PIPE_DLY-1];
      assign lcd_vsync = vs_dly_q[PIPE_DLY-1];
   end else begin : g_nodly
      assign lcd_de    = ready_q;
      assign lcd_hsync = hs_q;
      assign lcd_vsync = vs_q;
   end

endmodule

// File: tb/tb_lcd_sync_module.sv
// Self-checking bench for lcd_sync_module: three delay builds on a reduced raster,
// checked against a frame-position reference model.
module tb_lcd_sync_module;

   localparam int HS = 4, HBP = 3, HA = 10, HFP = 2;
   localparam int VS = 2, VBP = 2, VA = 5, VFP = 1;
   localparam int HT = HS + HBP + HA + HFP;
   localparam int VT = VS + VBP + VA + VFP;
   localparam int FRAME = HT * VT;
   localparam int HSTART = HS + HBP;
   localparam int VSTART = VS + VBP;
   localparam int FIRST_RDY = VSTART * HT + HSTART + 1;
   localparam int DLY [3] = '{0, 2, 7};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic        rdy [3];
   logic        fs  [3];
   logic        hs  [3];
   logic        vs  [3];
   logic        de  [3];
   logic [10:0] col [3];
   logic [10:0] row [3];

   always #5 clk = ~clk;

   lcd_sync_module #(
      .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
      .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP), .PIPE_DLY(0)
   ) u_d0 (
      .clk(clk), .rst(rst), .en(en), .ready_sig(rdy[0]), .column_addr_sig(col[0]),
      .row_addr_sig(row[0]), .frame_start_sig(fs[0]), .lcd_hsync(hs[0]),
      .lcd_vsync(vs[0]), .lcd_de(de[0])
   );

   lcd_sync_module #(
      .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
      .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP), .PIPE_DLY(2)
   ) u_dut (
      .clk(clk), .rst(rst), .en(en), .ready_sig(rdy[1]), .column_addr_sig(col[1]),
      .row_addr_sig(row[1]), .frame_start_sig(fs[1]), .lcd_hsync(hs[1]),
      .lcd_vsync(vs[1]), .lcd_de(de[1])
   );

   lcd_sync_module #(
      .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
      .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP), .PIPE_DLY(7)
   ) u_d7 (
      .clk(clk), .rst(rst), .en(en), .ready_sig(rdy[2]), .column_addr_sig(col[2]),
      .row_addr_sig(row[2]), .frame_start_sig(fs[2]), .lcd_hsync(hs[2]),
      .lcd_vsync(vs[2]), .lcd_de(de[2])
   );

   int checks = 0;
   int errors = 0;

   // Reference model: position within the frame, plus history of undelayed panel values.
   int p = 0;
   int edge_n = 0;
   int last_rst = 0;
   logic [2:0] hist [16];
   logic m_rdy, m_fs, m_hs, m_vs;
   int m_col, m_row;

   function automatic logic [2:0] exp_panel(input int d);
      if (edge_n - d >= last_rst) return hist[(edge_n - d) % 16];
      return 3'b011;
   endfunction

   task automatic tick(input logic r, input logic e);
      int x, y;
      rst = r;
      en  = e;
      @(posedge clk);
      x = p % HT;
      y = p / HT;
      if (r) begin
         m_rdy = 0; m_col = 0; m_row = 0; m_fs = 0; m_hs = 1; m_vs = 1;
      end else begin
         m_rdy = e && x >= HSTART && x < HSTART + HA && y >= VSTART && y < VSTART + VA;
         m_col = m_rdy ? x - HSTART : 0;
         m_row = m_rdy ? y - VSTART : 0;
         m_fs  = e && (p == 0);
         m_hs  = !(e && x < HS);
         m_vs  = !(e && y < VS);
      end
      p = (r || !e) ? 0 : (p + 1) % FRAME;
      edge_n++;
      hist[edge_n % 16] = {m_rdy, m_hs, m_vs};
      if (r) last_rst = edge_n;
      #1;
   endtask

   task automatic test_reset();
      repeat (9) tick(1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({rdy[k], fs[k], de[k], hs[k], vs[k]} !== 5'b00011) begin
            errors++;
            $display("FAIL reset_flags dut%0d: got rdy/fs/de/hs/vs=%b, want 00011", k,
                     {rdy[k], fs[k], de[k], hs[k], vs[k]});
         end
         checks++;
         if (col[k] !== 11'd0 || row[k] !== 11'd0) begin
            errors++;
            $display("FAIL reset_addr dut%0d: got col=%0d row=%0d, want 0 0", k, col[k], row[k]);
         end
      end
   endtask

   task automatic test_full_frame();
      int runs, nrdy, hs_low, vs_low, nfs, first_rise, ec, er;
      logic prev;
      runs = 0; nrdy = 0; hs_low = 0; vs_low = 0; nfs = 0; first_rise = 0;
      ec = 0; er = 0; prev = 1'b0;
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      checks++;
      if (fs[1] !== 1'b1) begin
         errors++;
         $display("FAIL first_frame_start: got %b, want 1", fs[1]);
      end
      for (int n = 1; n <= FRAME; n++) begin
         if (rdy[1] && !prev) begin
            runs++;
            if (first_rise == 0) first_rise = n;
         end
         if (rdy[1]) begin
            nrdy++;
            checks++;
            if (col[1] !== 11'(ec) || row[1] !== 11'(er)) begin
               errors++;
               $display("FAIL addr_seq edge %0d: got col=%0d row=%0d, want %0d %0d", n,
                        col[1], row[1], ec, er);
            end
            ec++;
            if (ec == HA) begin
               ec = 0;
               er++;
            end
         end
         prev = rdy[1];
         if (fs[1]) nfs++;
         if (!hs[1]) hs_low++;
         if (!vs[1]) vs_low++;
         tick(1'b0, 1'b1);
      end
      checks++;
      if (first_rise !== FIRST_RDY) begin
         errors++;
         $display("FAIL first_ready_edge: got %0d, want %0d", first_rise, FIRST_RDY);
      end
      checks++;
      if (nrdy !== HA * VA || runs !== VA) begin
         errors++;
         $display("FAIL ready_count: got %0d cycles in %0d runs, want %0d in %0d", nrdy, runs,
                  HA * VA, VA);
      end
      checks++;
      if (nfs !== 1 || fs[1] !== 1'b1) begin
         errors++;
         $display("FAIL frame_period: got %0d pulses, next=%b, want 1 pulse then 1", nfs, fs[1]);
      end
      checks++;
      if (hs_low !== HS * VT || vs_low !== VS * HT) begin
         errors++;
         $display("FAIL sync_low: got hs=%0d vs=%0d, want %0d %0d", hs_low, vs_low, HS * VT,
                  VS * HT);
      end
   endtask

   task automatic test_pipe_offsets();
      int r_rise [3];
      int d_rise [3];
      for (int k = 0; k < 3; k++) begin
         r_rise[k] = -1;
         d_rise[k] = -1;
      end
      tick(1'b1, 1'b1);
      for (int n = 1; n <= FRAME; n++) begin
         tick(1'b0, 1'b1);
         for (int k = 0; k < 3; k++) begin
            if (rdy[k] && r_rise[k] < 0) r_rise[k] = n;
            if (de[k] && d_rise[k] < 0) d_rise[k] = n;
         end
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (r_rise[k] < 0 || d_rise[k] - r_rise[k] !== DLY[k]) begin
            errors++;
            $display("FAIL de_offset dut%0d: got %0d, want %0d", k, d_rise[k] - r_rise[k],
                     DLY[k]);
         end
      end
   endtask

   task automatic test_resume_timing(input string name);
      int n;
      tick(1'b0, 1'b1);
      checks++;
      if (fs[1] !== 1'b1) begin
         errors++;
         $display("FAIL %s_frame_start: got %b, want 1", name, fs[1]);
      end
      n = 1;
      while (rdy[1] !== 1'b1 && n < 2 * FRAME) begin
         tick(1'b0, 1'b1);
         n++;
      end
      checks++;
      if (n !== FIRST_RDY || col[1] !== 11'd0 || row[1] !== 11'd0) begin
         errors++;
         $display("FAIL %s_ready_rise: got edge %0d col=%0d row=%0d, want %0d 0 0", name, n,
                  col[1], row[1], FIRST_RDY);
      end
   endtask

   task automatic test_en_drop();
      tick(1'b1, 1'b1);
      repeat ((VSTART + 2) * HT + HSTART + 4 + 1) tick(1'b0, 1'b1);
      checks++;
      if (rdy[1] !== 1'b1 || col[1] !== 11'd4 || row[1] !== 11'd2) begin
         errors++;
         $display("FAIL drop_point: got rdy=%b col=%0d row=%0d, want 1 4 2", rdy[1], col[1],
                  row[1]);
      end
      tick(1'b0, 1'b0);
      checks++;
      if (rdy[1] !== 1'b0 || de[1] !== 1'b1) begin
         errors++;
         $display("FAIL drop_edge1: got rdy=%b de=%b, want 0 1", rdy[1], de[1]);
      end
      tick(1'b0, 1'b0);
      checks++;
      if (de[1] !== 1'b1) begin
         errors++;
         $display("FAIL drop_edge2: got de=%b, want 1", de[1]);
      end
      tick(1'b0, 1'b0);
      checks++;
      if (de[1] !== 1'b0 || hs[1] !== 1'b1 || vs[1] !== 1'b1) begin
         errors++;
         $display("FAIL drop_edge3: got de/hs/vs=%b%b%b, want 011", de[1], hs[1], vs[1]);
      end
      repeat (7) tick(1'b0, 1'b0);
      test_resume_timing("en_restore");
   endtask

   task automatic test_mid_reset();
      tick(1'b1, 1'b1);
      repeat ((VSTART + 1) * HT + HSTART + 6) tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({rdy[k], fs[k], de[k], hs[k], vs[k]} !== 5'b00011 || col[k] !== 11'd0 ||
             row[k] !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset dut%0d: got rdy/fs/de/hs/vs=%b col=%0d row=%0d", k,
                     {rdy[k], fs[k], de[k], hs[k], vs[k]}, col[k], row[k]);
         end
      end
      test_resume_timing("rst_release");
   endtask

   task automatic test_random();
      logic r, e;
      logic [2:0] ep;
      tick(1'b1, 1'b1);
      for (int n = 0; n < 4000; n++) begin
         r = ($urandom_range(0, 299) == 0);
         e = ($urandom_range(0, 59) != 0);
         tick(r, e);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdy[k] !== m_rdy || fs[k] !== m_fs || col[k] !== 11'(m_col) ||
                row[k] !== 11'(m_row)) begin
               errors++;
               $display("FAIL rand_pixel dut%0d cyc %0d: got rdy=%b fs=%b col=%0d row=%0d, want %b %b %0d %0d",
                        k, n, rdy[k], fs[k], col[k], row[k], m_rdy, m_fs, m_col, m_row);
            end
            ep = exp_panel(DLY[k]);
            checks++;
            if ({de[k], hs[k], vs[k]} !== ep) begin
               errors++;
               $display("FAIL rand_panel dut%0d cyc %0d: got de/hs/vs=%b, want %b", k, n,
                        {de[k], hs[k], vs[k]}, ep);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) hist[i] = 3'b011;
      test_reset();
      test_full_frame();
      test_pipe_offsets();
      test_en_drop();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
